uart_byte_rx: RTL
=================

# uart_byte_rx

Serial-to-byte receiver for the messaging unit: oversamples the incoming 8N1 UART line on `clk_50M`, rebuilds each character LSB-first and presents it as a parallel byte with a one-cycle completion strobe. Its `rx[7:0]` / `rx_complete` outputs feed the message receiver directly, which assembles the 12-byte unit-status messages. Framing errors are flagged and force a wait for an idle (high) line before the next start bit is accepted.

## Interface
- `CLKS_PER_BIT`, default 434: clocks per bit (50 MHz / 115200 baud); legal range 4 to 65535.
- `clk_50M`  in  1  system clock, 50 MHz.
- `reset`  in  1  synchronous, active-high reset.
- `rx_serial`  in  1  asynchronous UART line, idle high.
- `rx`  out  8  last received byte, held until the next completion.
- `rx_complete`  out  1  one-cycle strobe: `rx` and the error flags were updated this cycle.
- `frame_err`  out  1  stop bit of the last byte sampled low; updated with each `rx_complete`.
- `parity_err`  out  1  parity mismatch on the last byte; constant 0 unless `UART_RX_PARITY_EN` is defined.
- `busy`  out  1  high in every state except IDLE.

## Operation
- Two-flop synchronizer on `rx_serial`, reset value 1. All logic uses the synchronized value `s_rx`.
- A 16-bit bit-timer `cnt` and a 3-bit bit index `bit_idx` (wraps 7 -> 0) drive the state machine.
- State machine:
  - **IDLE**: `cnt`=0. If `s_rx`==0, go to START.
  - **START**: `cnt` counts up. At `cnt`==CLKS_PER_BIT/2 − 1 (integer division), sample `s_rx`.
    - If 0: clear `cnt` and `bit_idx`, go to DATA.
    - If 1: glitch; go to IDLE with no strobe and no flag change.
  - **DATA**: at `cnt`==CLKS_PER_BIT−1, sample `s_rx` into `shift[bit_idx]` and clear `cnt`. After bit 7, go to PARITY if the macro is enabled, otherwise to STOP.
  - **PARITY**: only with the macro. Sample at `cnt`==CLKS_PER_BIT−1, then go to STOP.
  - **STOP**: sample at `cnt`==CLKS_PER_BIT−1. In that cycle:
    - load `rx`<=`shift`.
    - `frame_err`<=~`s_rx`.
    - `parity_err`<= computed mismatch (or 0 without the macro).
    - `rx_complete`<=1.
    - If `s_rx`==1, go to IDLE; otherwise go to WAIT_HIGH.
  - **WAIT_HIGH**: stay until `s_rx`==1, then go to IDLE.
- A byte with a framing error is still delivered on `rx`. Consumers decide whether to use it, based on `frame_err`.

## Timing
- Reset values:
  - `rx`=0x00, `rx_complete`=0, `frame_err`=0, `parity_err`=0, `busy`=0.
  - State IDLE, `cnt`=0, `bit_idx`=0, `shift`=0, synchronizer flops=1.
- Reset mid-frame aborts the frame immediately: no strobe, and the outputs take their reset values on the next edge.
- Registered outputs; `rx_complete` is high for exactly one cycle.
- Latency without parity:
  - `rx_complete` rises CLKS_PER_BIT/2 + 9·CLKS_PER_BIT cycles after the IDLE cycle that first sees `s_rx`==0.
  - Default: 217 + 3906 = 4123 cycles, plus 2 cycles of synchronizer delay from the pin edge.
  - With parity: add CLKS_PER_BIT (4557 cycles).
- The return to IDLE happens at mid-stop-bit, leaving ≥ half a bit to catch the next start edge. Back-to-back frames with no idle gap are received without loss.
- `busy` rises the cycle after start detection and falls the cycle the state returns to IDLE.
- A line low for fewer than CLKS_PER_BIT/2 cycles never produces a strobe.

## Configuration
- `UART_RX_PARITY_EN`:
  - Defined: frame is 8E1. The PARITY state is present; `parity_err` = (XOR of the 8 data bits) XOR the sampled parity bit.
  - Undefined: frame is 8N1. The PARITY state is removed; `parity_err` is tied 0.

## Test plan
- 0x55 sent at 434 clocks/bit, clean stop bit -> `rx`=0x55, `frame_err`=0, `rx_complete` high for 1 cycle exactly 4125 cycles after the pin's falling edge.
- 150-cycle low glitch on an idle line -> `busy` pulses high then returns low; no `rx_complete`; `rx` unchanged.
- 0xA3 sent with stop bit forced low, line held low 2000 cycles, then high -> `rx`=0xA3 and `frame_err`=1 with the strobe; no further strobe while low; the next 0x31 is received correctly with `frame_err`=0.
- "C" (0x43) then "U" (0x55) back-to-back, zero idle gap -> two strobes 4340 cycles apart carrying 0x43 then 0x55.
- `reset` asserted during bit 4 of 0xFF -> no strobe, all outputs 0. Next frame 0x45 is received normally.
- With `UART_RX_PARITY_EN`: 0x07 with parity bit 1 -> `parity_err`=0. Same byte with parity bit 0 -> `parity_err`=1; `rx`=0x07 in both cases.

Source files
------------

// File: rtl/uart_byte_rx.sv
// uart_byte_rx
//   Oversampling UART receiver. Rebuilds each character LSB-first from the
//   synchronized line and presents it as a parallel byte with a one-cycle
//   completion strobe. A framing error (low stop bit) is flagged. The
//   receiver then waits for the line to return high before it accepts
//   another start bit.
//
//   Optional feature: define UART_RX_PARITY_EN for 8E1 frames (parity state
//   present, parity_err live). Left undefined, frames are 8N1 and parity_err
//   is tied low.
//
// Parameters
//   CLKS_PER_BIT  clk_50M cycles per bit, 4..65535 (434 = 115200 baud)
//
// Ports
//   clk_50M      in   system clock
//   reset        in   synchronous, active-high reset
//   rx_serial    in   asynchronous UART line, idle high
//   rx[7:0]      out  last received byte, held until the next completion
//   rx_complete  out  one-cycle strobe: rx and the error flags updated
//   frame_err    out  stop bit of the last byte sampled low
//   parity_err   out  parity mismatch on the last byte (8E1 build only)
//   busy         out  receiver is not idle
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | line idle, waiting for a falling edge
// START     | timing to mid start bit; a high sample there is a glitch
// DATA      | sampling 8 data bits, one per bit period, LSB first
// PARITY    | sampling the parity bit (8E1 build only)
// STOP      | sampling the stop bit; byte and flags are published here
// WAIT_HIGH | stop bit was low; hold off until the line goes high again

module uart_byte_rx #(
   parameter int unsigned CLKS_PER_BIT = 434
) (
   input  logic       clk_50M,
   input  logic       reset,
   input  logic       rx_serial,
   output logic [7:0] rx,
   output logic       rx_complete,
   output logic       frame_err,
   output logic       parity_err,
   output logic       busy
);

   localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
   localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_RX_PARITY_EN
      PARITY,
`endif
      STOP,
      WAIT_HIGH
   } state_t;

   state_t      state;
   logic [15:0] cnt;
   logic [2:0]  bit_idx;
   logic [7:0]  shift;
   logic        sync_0;
   logic        s_rx;
`ifdef UART_RX_PARITY_EN
   logic        par_bit;
`endif

   always_ff @(posedge clk_50M) begin
      if (reset) begin
         sync_0 <= 1'b1;
         s_rx   <= 1'b1;
      end else begin
         sync_0 <= rx_serial;
         s_rx   <= sync_0;
      end
   end

   always_ff @(posedge clk_50M) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         bit_idx     <= '0;
         shift       <= '0;
         rx          <= '0;
         rx_complete <= 1'b0;
         frame_err   <= 1'b0;
         parity_err  <= 1'b0;
         busy        <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bit     <= 1'b0;
`endif
      end else begin
         rx_complete <= 1'b0;
         case (state)
            IDLE: begin
               cnt <= '0;
               if (!s_rx) begin
                  state <= START;
                  busy  <= 1'b1;
               end
            end
            START: begin
               if (cnt == HALF_M1) begin
                  cnt <= '0;
                  if (!s_rx) begin
                     bit_idx <= '0;
                     state   <= DATA;
                  end else begin
                     // line went back high before mid start bit: glitch
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            DATA: begin
               if (cnt == FULL_M1) begin
                  cnt            <= '0;
                  shift[bit_idx] <= s_rx;
                  bit_idx        <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                     state <= PARITY;
`else
                     state <= STOP;
`endif
                  end
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (cnt == FULL_M1) begin
                  cnt     <= '0;
                  par_bit <= s_rx;
                  state   <= STOP;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
`endif
            STOP: begin
               if (cnt == FULL_M1) begin
                  cnt         <= '0;
                  rx          <= shift;
                  frame_err   <= ~s_rx;
                  rx_complete <= 1'b1;
`ifdef UART_RX_PARITY_EN
                  parity_err  <= (^shift) ^ par_bit;
`else
                  parity_err  <= 1'b0;
`endif
                  // leave at mid stop bit so a back-to-back start edge is caught
                  if (s_rx) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end else begin
                     state <= WAIT_HIGH;
                  end
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            WAIT_HIGH: begin
               if (s_rx) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
